bitonic_sorter_pipelined: RTL



---
 rtl/bitonic_sorter_pipelined.sv | 125 ++++++++++++
 1 files changed

// File: rtl/bitonic_sorter_pipelined.sv
// bitonic_sorter_pipelined: parametrised bitonic sort network, pipelined with valid/ready and per-vector direction
// Optional BITONIC_SORTER_PIPELINED_INDEX_EN carries original input positions alongside keys and tie-breaks on them.
module bitonic_sorter_pipelined #(
  parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
  parameter int NUM_WAY = 16,
  parameter int COLS_PER_STAGE = 3
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] pre_sort_flatted_in,
  input  logic descend_in,
  input  logic in_valid_in,
  output logic in_ready_out,
  output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] post_sort_flatted_out,
`ifdef BITONIC_SORTER_PIPELINED_INDEX_EN
  output logic [NUM_WAY*$clog2(NUM_WAY)-1:0] sort_index_flatted_out,
`endif
  output logic out_valid_out,
  input  logic out_ready_in,
  output logic busy_out
);
  localparam int W = SINGLE_WAY_WIDTH_IN_BITS;
  localparam int N = NUM_WAY;
  localparam int K = $clog2(N);
  localparam int C = K * (K + 1) / 2;
  localparam int L = (C + COLS_PER_STAGE - 1) / COLS_PER_STAGE;
`ifdef BITONIC_SORTER_PIPELINED_INDEX_EN
  localparam int XW = K;
`else
  localparam int XW = 0;
`endif
  // element = {key, index}: comparing the whole element gives the index tie-break for free
  localparam int EW = W + XW;

  function automatic int col_p(input int c);
    int r;
    r = K;
    for (int p = K; p >= 1; p--) if (c < p * (p + 1) / 2) r = p;
    return r;
  endfunction

  logic [EW-1:0] in_elem [N];
  logic [EW-1:0] data_q [L][N];
  logic [EW-1:0] data_d [L][N];
  logic [L-1:0] valid_q, valid_d, desc_q, desc_d;
  logic advance;
  logic unused_desc;

  assign out_valid_out = valid_q[L-1];
  assign advance = !out_valid_out | out_ready_in;
  assign in_ready_out = advance;
  assign busy_out = |valid_q;
  assign unused_desc = desc_q[L-1];

  for (genvar i = 0; i < N; i++) begin : g_io
`ifdef BITONIC_SORTER_PIPELINED_INDEX_EN
    assign in_elem[i] = {pre_sort_flatted_in[i*W +: W], K'(i)};
    assign sort_index_flatted_out[i*K +: K] = data_q[L-1][i][K-1:0];
`else
    assign in_elem[i] = pre_sort_flatted_in[i*W +: W];
`endif
    assign post_sort_flatted_out[i*W +: W] = data_q[L-1][i][EW-1 -: W];
  end

  for (genvar c = 0; c < C; c++) begin : g_col
    localparam int P = col_p(c);
    localparam int S = P - 1 - (c - P * (P - 1) / 2);
    localparam int J = c / COLS_PER_STAGE;
    logic [EW-1:0] a [N];
    logic [EW-1:0] o [N];
    logic d;
    if (c % COLS_PER_STAGE != 0) begin : g_chain
      assign d = g_col[c-1].d;
      for (genvar i = 0; i < N; i++) begin : g_a
        assign a[i] = g_col[c-1].o[i];
      end
    end else if (J == 0) begin : g_first
      assign d = descend_in;
      for (genvar i = 0; i < N; i++) begin : g_a
        assign a[i] = in_elem[i];
      end
    end else begin : g_reg
      assign d = desc_q[J-1];
      for (genvar i = 0; i < N; i++) begin : g_a
        assign a[i] = data_q[J-1][i];
      end
    end
    for (genvar i = 0; i < N; i++) begin : g_pair
      if (((i >> S) & 1) == 0) begin : g_lo
        localparam int M = i + (1 << S);
        localparam bit ODD = ((i >> P) & 1) == 1;
        logic sw;
        // strict compare so equal elements stay put
        assign sw = (ODD ^ d) ? (a[i] < a[M]) : (a[i] > a[M]);
        assign o[i] = sw ? a[M] : a[i];
        assign o[M] = sw ? a[i] : a[M];
      end
    end
  end

  for (genvar j = 0; j < L; j++) begin : g_stage
    localparam int LC = ((j + 1) * COLS_PER_STAGE < C ? (j + 1) * COLS_PER_STAGE : C) - 1;
    assign desc_d[j] = g_col[LC].d;
    for (genvar i = 0; i < N; i++) begin : g_d
      assign data_d[j][i] = g_col[LC].o[i];
    end
    if (j == 0) begin : g_v0
      assign valid_d[j] = in_valid_in;
    end else begin : g_vn
      assign valid_d[j] = valid_q[j-1];
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      valid_q <= '0;
      desc_q <= '0;
      data_q <= '{default: '0};
    end else if (advance) begin
      valid_q <= valid_d;
      desc_q <= desc_d;
      data_q <= data_d;
    end
  end
endmodule
